// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Optional feature macro: MD_DIVZERO_HOLD_EN (divide by zero leaves HI/LO unchanged).
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        WriteHi,
  input  logic        WriteLo,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned W    = 32;
  localparam int unsigned CW   = 5;
  localparam logic [0:0]  IDLE = 1'b0;
  localparam logic [0:0]  RUN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  tmp_hi_q, tmp_hi_d;
  logic [W-1:0]  tmp_lo_q, tmp_lo_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic          busy_q, busy_d;
`ifdef MD_DIVZERO_HOLD_EN
  logic          keep_q, keep_d;
`endif

  logic          is_signed;
  logic [2*W-1:0] ext_a, ext_b, prod;
  logic          a_neg, b_neg, b_zero;
  logic [W-1:0]  a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;
  logic [2*W-1:0] div_res, result;

  // Full 64-bit result of the operation being launched this cycle.
  always_comb begin
    is_signed = MDOp[0];
    ext_a     = {{W{is_signed & A[W-1]}}, A};
    ext_b     = {{W{is_signed & B[W-1]}}, B};
    prod      = ext_a * ext_b;

    a_neg  = is_signed & A[W-1];
    b_neg  = is_signed & B[W-1];
    b_zero = (B == '0);
    a_mag  = a_neg ? (~A + W'(1)) : A;
    b_mag  = b_neg ? (~B + W'(1)) : B;
    // A divisor of one keeps the divider defined when B is zero; that result is discarded.
    b_safe = b_zero ? W'(1) : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quot   = (a_neg ^ b_neg) ? (~q_mag + W'(1)) : q_mag;
    rem    = a_neg ? (~r_mag + W'(1)) : r_mag;

    div_res = b_zero ? {A, {W{1'b1}}} : {rem, quot};
    result  = MDOp[1] ? div_res : prod;
  end

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
`ifdef MD_DIVZERO_HOLD_EN
    keep_d   = keep_q;
`endif
    case (state_q)
      IDLE: begin
        if (Start) begin
          tmp_hi_d = result[2*W-1:W];
          tmp_lo_d = result[W-1:0];
          cnt_d    = MDOp[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          state_d  = RUN;
          busy_d   = 1'b1;
`ifdef MD_DIVZERO_HOLD_EN
          keep_d   = MDOp[1] & b_zero;
`endif
        end else begin
          if (WriteHi) hi_d = A;
          if (WriteLo) lo_d = A;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
`ifdef MD_DIVZERO_HOLD_EN
          if (!keep_q) begin
            hi_d = tmp_hi_q;
            lo_d = tmp_lo_q;
          end
`else
          hi_d = tmp_hi_q;
          lo_d = tmp_lo_q;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tmp_hi_q <= '0;
      tmp_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
`ifdef MD_DIVZERO_HOLD_EN
      keep_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
`ifdef MD_DIVZERO_HOLD_EN
      keep_q   <= keep_d;
`endif
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_md_unit;

  localparam int unsigned NMUL = 5;
  localparam int unsigned NDIV = 10;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [1:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        WriteHi;
  logic        WriteLo;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  md_unit #(.MULT_CYCLES(NMUL), .DIV_CYCLES(NDIV)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
    .WriteHi(WriteHi), .WriteLo(WriteLo), .Busy(Busy), .HI(HI), .LO(LO)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: absolute edge numbers instead of a counter.
  logic [31:0] m_hi, m_lo;
  logic        m_busy;
  logic [63:0] m_res;
  logic        m_keep;
  int          m_edge, m_done;

  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int     sa, sb;
    longint x, y, q, r, p;
    logic [63:0] u;
    sa = a;
    sb = b;
    x  = longint'(sa);
    y  = longint'(sb);
    case (op)
      2'd0: begin u = {32'd0, a} * {32'd0, b}; return u; end
      2'd1: begin p = x * y; return 64'(p); end
      2'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  function automatic bit hold_mode();
`ifdef MD_DIVZERO_HOLD_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_step();
    m_edge++;
    if (Reset) begin
      m_hi = 0; m_lo = 0; m_busy = 0; m_keep = 0; m_res = 0;
    end else if (m_busy) begin
      if (m_edge == m_done) begin
        m_busy = 0;
        if (!m_keep) {m_hi, m_lo} = m_res;
      end
    end else if (Start) begin
      m_res  = ref_result(MDOp, A, B);
      m_keep = hold_mode() && MDOp[1] && (B == 0);
      m_busy = 1;
      m_done = m_edge + (MDOp[1] ? int'(NDIV) : int'(NMUL));
    end else begin
      if (WriteHi) m_hi = A;
      if (WriteLo) m_lo = A;
    end
  endtask

  task automatic compare_outputs();
    n_vec++;
    if (Busy !== m_busy || HI !== m_hi || LO !== m_lo) begin
      n_err++;
      $display("FAIL cycle_check edge %0d: got busy=%0b hi=%h lo=%h, expected busy=%0b hi=%h lo=%h",
               m_edge, Busy, HI, LO, m_busy, m_hi, m_lo);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Entered at a negedge; drives inputs, steps the model at the edge, checks at the next negedge.
  task automatic cyc(input logic st, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic wh, input logic wl, input logic rst);
    Start = st; MDOp = op; A = a; B = b; WriteHi = wh; WriteLo = wl; Reset = rst;
    @(posedge Clk);
    model_step();
    @(negedge Clk);
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 2'd0, $urandom, $urandom, 0, 0, 0);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cycles);
    busy_cycles = 0;
    cyc(1, op, a, b, 0, 0, 0);
    for (int i = 0; i < 64 && Busy; i++) begin
      busy_cycles++;
      idle(1);
    end
    if (Busy) begin
      n_vec++; n_err++;
      $display("FAIL run_op_timeout: busy still %0b after 64 cycles, expected 0", Busy);
    end
  endtask

  int bc;
  logic [31:0] specials [8] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                                32'h7FFF_FFFF, 32'h2, 32'hFFFF_FFF9, 32'h0000_0007};

  initial begin
    m_edge = 0; m_done = 0; m_busy = 0; m_hi = 0; m_lo = 0; m_res = 0; m_keep = 0;
    Start = 0; MDOp = 0; A = 0; B = 0; WriteHi = 0; WriteLo = 0; Reset = 1;
    @(negedge Clk);
    cyc(0, 2'd0, 0, 0, 0, 0, 1);
    lit("reset_busy", 32'(Busy), 32'd0);
    lit("reset_hi", HI, 32'd0);
    lit("reset_lo", LO, 32'd0);

    run_op(2'd0, 32'hFFFF_FFFF, 32'd2, bc);
    lit("multu_busy_cycles", 32'(bc), 32'd5);
    lit("multu_hi", HI, 32'h0000_0001);
    lit("multu_lo", LO, 32'hFFFF_FFFE);

    run_op(2'd1, 32'hFFFF_FFFD, 32'd7, bc);
    lit("mult_busy_cycles", 32'(bc), 32'd5);
    lit("mult_hi", HI, 32'hFFFF_FFFF);
    lit("mult_lo", LO, 32'hFFFF_FFEB);

    run_op(2'd3, 32'hFFFF_FFF9, 32'd2, bc);
    lit("div_busy_cycles", 32'(bc), 32'd10);
    lit("div_lo", LO, 32'hFFFF_FFFD);
    lit("div_hi", HI, 32'hFFFF_FFFF);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, bc);
    lit("divu_lo", LO, 32'h7FFF_FFFC);
    lit("divu_hi", HI, 32'h0000_0001);

    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, bc);
    lit("div_ovf_lo", LO, 32'h8000_0000);
    lit("div_ovf_hi", HI, 32'h0000_0000);

    cyc(0, 2'd0, 32'h1111_1111, 0, 1, 1, 0);
    lit("mthi_mtlo_hi", HI, 32'h1111_1111);
    lit("mthi_mtlo_lo", LO, 32'h1111_1111);
    run_op(2'd2, 32'd5, 32'd0, bc);
    lit("divz_busy_cycles", 32'(bc), 32'd10);
`ifdef MD_DIVZERO_HOLD_EN
    lit("divz_hi", HI, 32'h1111_1111);
    lit("divz_lo", LO, 32'h1111_1111);
`else
    lit("divz_hi", HI, 32'h0000_0005);
    lit("divz_lo", LO, 32'hFFFF_FFFF);
`endif

    cyc(1, 2'd1, 32'd3, 32'd5, 0, 0, 0);
    cyc(1, 2'd3, 32'd9, 32'd0, 0, 0, 0);
    cyc(0, 2'd0, 32'h0000_AAAA, 0, 1, 0, 0);
    cyc(0, 2'd0, 32'h0000_BBBB, 0, 0, 1, 0);
    for (int i = 0; i < 16 && Busy; i++) idle(1);
    lit("inflight_hi", HI, 32'd0);
    lit("inflight_lo", LO, 32'd15);
    cyc(1, 2'd0, 32'd4, 32'd4, 0, 1, 0);
    lit("start_wins_lo_pending", LO, 32'd15);
    for (int i = 0; i < 16 && Busy; i++) idle(1);
    lit("start_wins_lo", LO, 32'd16);

    cyc(1, 2'd3, 32'd100, 32'd7, 0, 0, 0);
    idle(2);
    cyc(0, 2'd0, 0, 0, 0, 0, 1);
    lit("abort_busy", 32'(Busy), 32'd0);
    lit("abort_hi", HI, 32'd0);
    lit("abort_lo", LO, 32'd0);
    idle(1);
    cyc(0, 2'd0, 32'h1234, 0, 0, 1, 0);
    lit("mtlo_after_abort", LO, 32'h0000_1234);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 7)] : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
           (($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 7)] : $urandom);
      cyc($urandom_range(0, 3) == 0, 2'($urandom), ra, rb,
          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
